// File: rtl/chan_mux_arb.sv
// rtl/chan_mux_arb.sv - N-channel registered mux with fixed-select or round-robin grant
// Optional accepted-beat counter enabled by defining MUX_CNT_EN.
module chan_mux_arb #(
    parameter  int W  = 9,
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic [N*W-1:0] di_i,
    input  logic [N-1:0]   vi_i,
    output logic [N-1:0]   ri_o,
    input  logic           mode_i,
    input  logic [SW-1:0]  s_i,
    output logic [W-1:0]   do_o,
    output logic           vo_o,
    input  logic           ro_i,
    output logic [SW-1:0]  so_o,
    output logic [15:0]    cnt_o
);

    logic [W-1:0]  do_q,  do_d;
    logic          vo_q,  vo_d;
    logic [SW-1:0] so_q,  so_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          ld;
    logic [SW-1:0] g;
    logic          gv;
    logic          fix_v;
    logic [SW-1:0] rr_g;
    logic [N-1:0]  rot;
    logic [W-1:0]  sel_data;

    // rot[j] is the valid of channel (ptr+1+j) mod N, so the lowest set bit is the next grant
    always_comb begin
        rot  = N'({vi_i, vi_i} >> (ptr_q + SW'(1)));
        rr_g = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                rr_g = SW'((int'(ptr_q) + 1 + j) % N);
            end
        end
    end

    // An out-of-range S never matches a channel, leaving fix_v low
    always_comb begin
        fix_v = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (SW'(k) == s_i) begin
                fix_v = vi_i[k];
            end
        end
    end

    always_comb begin
        ld = !vo_q || ro_i;
        if (mode_i) begin
            g  = rr_g;
            gv = |vi_i;
        end else begin
            g  = s_i;
            gv = fix_v;
        end
    end

    always_comb begin
        ri_o     = '0;
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (SW'(k) == g) begin
                ri_o[k]  = ld && gv;
                sel_data = di_i[k*W +: W];
            end
        end
    end

    always_comb begin
        do_d  = do_q;
        vo_d  = vo_q;
        so_d  = so_q;
        ptr_d = ptr_q;
        if (ld) begin
            if (gv) begin
                do_d = sel_data;
                so_d = g;
                vo_d = 1'b1;
                if (mode_i) begin
                    ptr_d = g;
                end
            end else begin
                vo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            do_q  <= '0;
            vo_q  <= 1'b0;
            so_q  <= '0;
            ptr_q <= SW'(N - 1);
        end else begin
            do_q  <= do_d;
            vo_q  <= vo_d;
            so_q  <= so_d;
            ptr_q <= ptr_d;
        end
    end

    assign do_o = do_q;
    assign vo_o = vo_q;
    assign so_o = so_q;

`ifdef MUX_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (vo_q && ro_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = 16'h0000;
`endif

endmodule

// File: doc/chan_mux_arb.md
# chan_mux_arb

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake. Each cycle it selects one input channel, either the one addressed by `S` (fixed mode) or the next requesting channel in round-robin order (arbitration mode), and captures that beat into a single output register. It replaces the fixed 4:1 combinational selectors in the lab datapath wherever several sources share one sink and need back-pressure.

## Interface
- `W`, 9: data width per channel.
- `N`, 4: channel count, 2..16; `SW = $clog2(N)` is a localparam.
- `CLK`  in  1  rising-edge clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `DI`  in  N*W  flattened channel data; channel k at `DI[k*W +: W]`.
- `VI`  in  N  per-channel valid.
- `RI`  out  N  per-channel ready, one-hot or zero.
- `MODE`  in  1  0 = fixed select by `S`, 1 = round-robin.
- `S`  in  SW  channel index used in fixed mode.
- `DO`  out  W  registered output data.
- `VO`  out  1  output valid.
- `RO`  in  1  downstream ready.
- `SO`  out  SW  index of the channel that produced `DO`.
- `CNT`  out  16  accepted-beat counter (see Configuration).

## Operation
- Load enable: `ld = !VO || RO`.
- Grant `g`, valid flag `gv`, both combinational:
  - Fixed mode: `g = S`; `gv = VI[S]`. `S >= N` (N not a power of two) gives `gv = 0`.
  - Round-robin mode: `g` is the first k with `VI[k]`, searching `ptr+1, ptr+2, …` modulo N. `gv = |VI`.
- `RI[k] = ld && gv && (k == g)`. At most one bit is set. `RI` never depends on `VI[k]` for k ≠ g except through `g`.
- Transfer on input k: `VI[k] && RI[k]`. On transfer: `DO <= DI[g]`, `SO <= g`, `VO <= 1`.
- `ld && !gv`: `VO <= 0`. `DO` and `SO` hold their values.
- `!ld` (VO=1, RO=0): `DO`, `SO` and `VO` hold. All `RI` are 0.
- Round-robin pointer `ptr` (SW bits): updates to `g` on every transfer while MODE=1. It holds during fixed mode.
- `MODE` and `S` are sampled every cycle and take effect at the next selection. A beat already in the output register is unaffected by a change.
- Reset values: `DO=0`, `VO=0`, `SO=0`, `ptr=N-1` so the first round-robin search starts at channel 0, `CNT=0`. Reset asserted mid-transfer discards the registered beat immediately, because the reset is asynchronous.

## Timing
- Latency is 1 cycle: a beat transferred at edge t is on `DO`/`VO` after edge t.
- Throughput is one beat per cycle while `RO=1`. A simultaneous downstream accept and upstream load at the same edge is legal and required.
- There are no combinational paths from `VI`/`DI` to `DO`/`VO`. The `RO`→`RI` path is combinational and is permitted.
- Fairness: with all N channels continuously valid in round-robin mode, grants follow the sequence 0,1,…,N-1,0,…, with no channel skipped or repeated.
- Pointer wrap: after a grant to N-1, the next search starts at 0.

## Configuration
- `MUX_CNT_EN` defined: `CNT` increments by 1 on every output accept (`VO && RO`). It wraps from 0xFFFF to 0x0000, and reset clears it to 0.
- `MUX_CNT_EN` undefined: `CNT` is tied to 16'h0000 and no counter register is built. All other behaviour is identical.

## Test plan
- Reset, fixed mode, N=4, W=9: hold RO=1, MODE=0, S=2, VI=4'b0100, DI ch2=9'h1A5 → RI=4'b0100; the next cycle DO=9'h1A5, SO=2, VO=1. Drop VI → VO=0 one cycle later.
- Back-pressure: VO=1, RO=0 for 3 cycles with VI=4'b1111 → RI=0, DO/SO stable. When RO=1, exactly one new beat loads in the same cycle.
- Round-robin fairness: MODE=1, VI=4'b1111, RO=1 for 8 cycles → SO sequence 0,1,2,3,0,1,2,3 with VO continuously 1.
- Sparse round robin: after a grant to ch1, set VI=4'b0011 → next grant is ch0 (wrap), then ch1. VI=0 → VO drops to 0 and ptr holds.
- Fixed mode on an invalid or out-of-range channel: N=3, S=3 with VI=3'b111 → RI=0 and VO falls to 0 once the current beat is accepted.
- Counter and reset, with `MUX_CNT_EN`: preload by 65535 accepts, then one more → CNT=0. Assert RST_N=0 mid-stream → VO, DO, SO and CNT go to 0 without waiting for a clock edge; after release the first round-robin grant is ch0.
